// File: rtl/mux_pkg.sv
// Shared types and constants for the mux_n_scan block: FSM encoding, reset values,
// and the select-width helper.
package mux_pkg;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  localparam state_t RST_STATE = ST_MANUAL;
  localparam logic   RST_BIT   = 1'b0;

  // Bits needed to index n items, never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/mux_dwell_counter.sv
// Scan sequencer: dwells DWELL cycles per channel, then steps to the next one,
// pulsing wrap when it rolls over from the last channel back to channel 0.
module mux_dwell_counter
  import mux_pkg::*;
#(
  parameter int DWELL    = 16,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = clog2(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  output logic [SEL_W-1:0] cur_sel,
  output logic [SEL_W-1:0] sel_next,
  output logic             wrap
);

  localparam int CNT_W = clog2(DWELL);

  logic [CNT_W-1:0] count_q;
  logic [SEL_W-1:0] sel_q;
  logic             wrap_q;
  logic             last_cnt;
  logic             last_ch;

  assign last_cnt = (count_q == CNT_W'(DWELL - 1));
  assign last_ch  = (sel_q == SEL_W'(CHANNELS - 1));

  // sel_next lets the parent register Y against the channel it will show next cycle.
  always_comb begin
    sel_next = sel_q;
    if (clear) begin
      sel_next = '0;
    end else if (en && last_cnt) begin
      sel_next = last_ch ? '0 : sel_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count_q <= '0;
      sel_q   <= '0;
      wrap_q  <= RST_BIT;
    end else if (en) begin
      count_q <= last_cnt ? '0 : count_q + 1'b1;
      sel_q   <= sel_next;
      wrap_q  <= last_cnt && last_ch;
    end else begin
      wrap_q  <= 1'b0;
    end
  end

  assign cur_sel = sel_q;
  assign wrap    = wrap_q;

endmodule

// File: rtl/mux_n_scan.sv
// Registered N:1 multiplexer with manual select and optional auto-scan.
// Scan mode is built only when MUX_N_SCAN_SCAN_EN is defined; otherwise manual only.
module mux_n_scan
  import mux_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 16,
  localparam int SEL_W   = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] data,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      hold,
  output logic [WIDTH-1:0]          Y,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      wrap,
  output logic                      sel_err
);

  logic [WIDTH-1:0] chan [CHANNELS];
  logic             sel_bad;
  logic [SEL_W-1:0] man_sel;
  logic [SEL_W-1:0] man_sel_q;
  logic [SEL_W-1:0] pick;
  logic             err_d;
  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] y_q;
  logic             sel_err_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    assign chan[k] = data[k*WIDTH +: WIDTH];
  end

  // Out-of-range selects park on the last channel and flag an error.
  assign sel_bad = (int'(sel) >= CHANNELS);
  assign man_sel = sel_bad ? SEL_W'(CHANNELS - 1) : sel;

`ifdef MUX_N_SCAN_SCAN_EN
  state_t           state_q;
  state_t           state_d;
  logic             scan_active;
  logic             cnt_clear;
  logic [SEL_W-1:0] scan_sel;
  logic [SEL_W-1:0] scan_next;
  logic             scan_wrap;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RST_STATE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_MANUAL: if (mode)  state_d = ST_SCAN;
      ST_SCAN:   if (!mode) state_d = ST_MANUAL;
    endcase
  end

  // Counter only runs across consecutive scan cycles; the entry cycle restarts it at 0.
  assign scan_active = (state_d == ST_SCAN);
  assign cnt_clear   = (state_q != ST_SCAN) || !scan_active;

  mux_dwell_counter #(
    .DWELL    (DWELL),
    .CHANNELS (CHANNELS)
  ) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (!hold),
    .clear    (cnt_clear),
    .cur_sel  (scan_sel),
    .sel_next (scan_next),
    .wrap     (scan_wrap)
  );

  assign pick    = scan_active ? scan_next : man_sel;
  assign err_d   = !scan_active && sel_bad;
  assign cur_sel = (state_q == ST_SCAN) ? scan_sel : man_sel_q;
  assign wrap    = scan_wrap;
`else
  logic unused_scan_inputs;

  assign unused_scan_inputs = ^{mode, hold};
  assign pick    = man_sel;
  assign err_d   = sel_bad;
  assign cur_sel = man_sel_q;
  assign wrap    = 1'b0;
`endif

  always_comb begin
    y_d = chan[pick];
    if (err_d) y_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q       <= '0;
      man_sel_q <= '0;
      sel_err_q <= RST_BIT;
    end else begin
      y_q       <= y_d;
      man_sel_q <= man_sel;
      sel_err_q <= err_d;
    end
  end

  assign Y       = y_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_mux_n_scan.sv
// Directed, table-driven bench for mux_n_scan: a 4-channel 1-bit instance and a
// 5-channel 8-bit instance; scan sequences run only when MUX_N_SCAN_SCAN_EN is defined.
module tb_mux_n_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  data4;
  logic [1:0]  sel4;
  logic        mode4, hold4;
  logic        y4;
  logic [1:0]  cs4;
  logic        wrap4, err4;

  logic [39:0] data5;
  logic [2:0]  sel5;
  logic        mode5, hold5;
  logic [7:0]  y5;
  logic [2:0]  cs5;
  logic        wrap5, err5;

  int checks = 0;
  int errors = 0;

  mux_n_scan #(.WIDTH(1), .CHANNELS(4), .DWELL(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .data(data4), .sel(sel4), .mode(mode4), .hold(hold4),
    .Y(y4), .cur_sel(cs4), .wrap(wrap4), .sel_err(err4)
  );

  mux_n_scan #(.WIDTH(8), .CHANNELS(5), .DWELL(4)) dut5 (
    .clk(clk), .rst_n(rst_n), .data(data5), .sel(sel5), .mode(mode5), .hold(hold5),
    .Y(y5), .cur_sel(cs5), .wrap(wrap5), .sel_err(err5)
  );

  typedef struct {
    logic [1:0] sel;
    logic [3:0] data;
    logic       y;
  } vec_t;

  vec_t vecs [10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] s, input logic [3:0] d);
    sel4  = s;
    data4 = d;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0] = '{2'd0, 4'b0001, 1'b1};
    vecs[1] = '{2'd1, 4'b0001, 1'b0};
    vecs[2] = '{2'd1, 4'b0010, 1'b1};
    vecs[3] = '{2'd2, 4'b0100, 1'b1};
    vecs[4] = '{2'd2, 4'b1011, 1'b0};
    vecs[5] = '{2'd3, 4'b1000, 1'b1};
    vecs[6] = '{2'd3, 4'b0111, 1'b0};
    vecs[7] = '{2'd0, 4'b1110, 1'b0};
    vecs[8] = '{2'd1, 4'b1101, 1'b0};
    vecs[9] = '{2'd2, 4'b1111, 1'b1};

    rst_n = 1'b0;
    sel4  = 2'd3; data4 = 4'hF; mode4 = 1'b0; hold4 = 1'b0;
    sel5  = 3'd6; data5 = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11}; mode5 = 1'b0; hold5 = 1'b0;
    tick();
    tick();
    checkOutput("reset Y", y4, 0);
    checkOutput("reset cur_sel", cs4, 0);
    checkOutput("reset wrap", wrap4, 0);
    checkOutput("reset sel_err", err4, 0);
    checkOutput("reset sel_err5", err5, 0);
    checkOutput("reset Y5", y5, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].sel, vecs[i].data);
      checkOutput($sformatf("manual Y vec%0d", i), y4, vecs[i].y);
      checkOutput($sformatf("manual cur_sel vec%0d", i), cs4, vecs[i].sel);
      checkOutput($sformatf("manual sel_err vec%0d", i), err4, 0);
    end

    hold4 = 1'b1;
    applyStimulus(2'd1, 4'b0010);
    checkOutput("manual hold Y", y4, 1);
    checkOutput("manual hold cur_sel", cs4, 1);
    hold4 = 1'b0;

    sel5 = 3'd4; tick();
    checkOutput("ch5 sel4 Y", y5, 8'h55);
    checkOutput("ch5 sel4 cur_sel", cs5, 4);
    checkOutput("ch5 sel4 sel_err", err5, 0);
    sel5 = 3'd5; tick();
    checkOutput("ch5 sel5 Y", y5, 0);
    checkOutput("ch5 sel5 sel_err", err5, 1);
    sel5 = 3'd6; tick();
    checkOutput("ch5 sel6 Y", y5, 0);
    checkOutput("ch5 sel6 cur_sel", cs5, 4);
    checkOutput("ch5 sel6 sel_err", err5, 1);
    sel5 = 3'd0; tick();
    checkOutput("ch5 sel0 Y", y5, 8'h11);
    checkOutput("ch5 sel0 sel_err", err5, 0);

`ifdef MUX_N_SCAN_SCAN_EN
    // Scan from reset release with data 1010: odd channels read 1.
    rst_n = 1'b0; mode4 = 1'b1; data4 = 4'b1010; tick();
    rst_n = 1'b1;
    for (int i = 0; i < 36; i++) begin
      tick();
      checkOutput($sformatf("scan cur_sel i%0d", i), cs4, (i / 4) % 4);
      checkOutput($sformatf("scan Y i%0d", i), y4, ((i / 4) % 4) & 1);
      checkOutput($sformatf("scan wrap i%0d", i), wrap4, (i == 16 || i == 32) ? 1 : 0);
    end

    // Hold at cur_sel=2, count=1.
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checkOutput("pre-hold cur_sel", cs4, 2);
    hold4 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) data4 = 4'b0100;
      tick();
      checkOutput($sformatf("hold cur_sel i%0d", i), cs4, 2);
      checkOutput($sformatf("hold wrap i%0d", i), wrap4, 0);
      checkOutput($sformatf("hold Y i%0d", i), y4, (i >= 5) ? 1 : 0);
    end
    hold4 = 1'b0;
    tick(); checkOutput("release +1 cur_sel", cs4, 2);
    tick(); checkOutput("release +2 cur_sel", cs4, 2);
    tick(); checkOutput("release +3 cur_sel", cs4, 3);

    // Reset mid-scan at cur_sel=3, with hold asserted and mode still 1.
    hold4 = 1'b1; rst_n = 1'b0; data4 = 4'b0101; tick();
    checkOutput("midscan reset Y", y4, 0);
    checkOutput("midscan reset cur_sel", cs4, 0);
    checkOutput("midscan reset wrap", wrap4, 0);
    checkOutput("midscan reset sel_err", err4, 0);
    rst_n = 1'b1; hold4 = 1'b0; tick();
    checkOutput("restart entry cur_sel", cs4, 0);
    checkOutput("restart entry Y", y4, 1);
    tick(); tick(); tick(); tick();
    checkOutput("restart step cur_sel", cs4, 1);
    checkOutput("restart step Y", y4, 0);

    // Leaving scan while hold is high: manual select takes over immediately.
    hold4 = 1'b1; mode4 = 1'b0; sel4 = 2'd3; data4 = 4'b1000; tick();
    checkOutput("exit scan cur_sel", cs4, 3);
    checkOutput("exit scan Y", y4, 1);
    checkOutput("exit scan wrap", wrap4, 0);
    hold4 = 1'b0;

    // Five channels: non-power-of-2 wrap, sel ignored even when out of range.
    sel5 = 3'd7; mode5 = 1'b1;
    for (int i = 0; i < 21; i++) begin
      tick();
      checkOutput($sformatf("scan5 cur_sel i%0d", i), cs5, (i / 4) % 5);
      checkOutput($sformatf("scan5 Y i%0d", i), y5, 8'h11 * (((i / 4) % 5) + 1));
      checkOutput($sformatf("scan5 sel_err i%0d", i), err5, 0);
      checkOutput($sformatf("scan5 wrap i%0d", i), wrap5, (i == 20) ? 1 : 0);
    end
`else
    begin
      int wraps;
      wraps = 0;
      mode4 = 1'b1; hold4 = 1'b0; sel4 = 2'd2; data4 = 4'b0100;
      mode5 = 1'b1; sel5 = 3'd6;
      for (int i = 0; i < 100; i++) begin
        tick();
        if (wrap4 !== 1'b0) wraps++;
      end
      checkOutput("manual-only wrap count", wraps, 0);
      checkOutput("manual-only Y", y4, 1);
      checkOutput("manual-only cur_sel", cs4, 2);
      checkOutput("manual-only sel_err5", err5, 1);
      checkOutput("manual-only wrap5", wrap5, 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
